alarm_timekeeper: RTL and testbench

Time-of-day and alarm core for the alarm clock. It consumes the divided 1 Hz square wave from the clock-divider stage and detects its rising edge in the clk domain. It keeps 24-hour BCD time (HH:MM:SS) and a BCD alarm time (HH:MM), and supports set modes driven by single-cycle button pulses. A small FSM raises alarm_ring for the display and buzzer stages downstream.

---
 rtl/alarm_timekeeper.sv | 168 ++++++++++++++++
 tb/tb_alarm_timekeeper.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_timekeeper.sv
// Time-of-day (24h BCD) and alarm core with set modes and alarm ring FSM.
// Optional snooze support is built when ALARM_SNOOZE_EN is defined.
module alarm_timekeeper #(
    parameter int unsigned RING_SEC   = 60,
    parameter int unsigned SNOOZE_MIN = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_in,
    input  logic [1:0] mode,
    input  logic       inc_min,
    input  logic       inc_hr,
    input  logic       alarm_en,
    input  logic       alarm_off,
    input  logic       snooze,
    output logic [7:0] hr_bcd,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic [7:0] al_hr_bcd,
    output logic [7:0] al_min_bcd,
    output logic       sec_tick,
    output logic       alarm_ring
);

    typedef enum logic [1:0] {
        MODE_RUN       = 2'b00,
        MODE_SET_TIME  = 2'b01,
        MODE_SET_ALARM = 2'b10,
        MODE_RUN_ALT   = 2'b11
    } mode_e;

`ifdef ALARM_SNOOZE_EN
    typedef enum logic [1:0] {IDLE, RINGING, SNOOZED} state_e;
`else
    typedef enum logic {IDLE, RINGING} state_e;
`endif

    localparam logic [15:0] RING_LAST = 16'(RING_SEC - 1);

    state_e      state, next_state;
    logic        tick_q;
    logic        rise;
    logic        set_time;
    logic        set_alarm;
    logic        trigger;
    logic        timeout;
    logic [15:0] ring_cnt;

    // Wraps to 00 at max, otherwise increments keeping both nibbles valid BCD.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
        if (v == max)
            return 8'h00;
        else if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'h0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    assign rise      = tick_in & ~tick_q;
    assign set_time  = (mode == MODE_SET_TIME);
    assign set_alarm = (mode == MODE_SET_ALARM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_q     <= '0;
            sec_tick   <= '0;
            hr_bcd     <= '0;
            min_bcd    <= '0;
            sec_bcd    <= '0;
            al_hr_bcd  <= '0;
            al_min_bcd <= '0;
        end else begin
            tick_q   <= tick_in;
            sec_tick <= rise & ~set_time;
            // Holding seconds at 00 for the whole set-time period is equivalent to clearing on entry.
            if (set_time) begin
                sec_bcd <= '0;
                if (inc_min) min_bcd <= bcd_inc(min_bcd, 8'h59);
                if (inc_hr)  hr_bcd  <= bcd_inc(hr_bcd, 8'h23);
            end else if (rise) begin
                sec_bcd <= bcd_inc(sec_bcd, 8'h59);
                if (sec_bcd == 8'h59) begin
                    min_bcd <= bcd_inc(min_bcd, 8'h59);
                    if (min_bcd == 8'h59) hr_bcd <= bcd_inc(hr_bcd, 8'h23);
                end
            end
            if (set_alarm) begin
                if (inc_min) al_min_bcd <= bcd_inc(al_min_bcd, 8'h59);
                if (inc_hr)  al_hr_bcd  <= bcd_inc(al_hr_bcd, 8'h23);
            end
        end
    end

    // sec_tick with seconds at 00 occurs once per minute, so the match fires once.
    assign trigger = sec_tick & (sec_bcd == 8'h00) & (hr_bcd == al_hr_bcd) &
                     (min_bcd == al_min_bcd) & alarm_en & ~set_time & ~set_alarm;
    assign timeout = sec_tick & (ring_cnt == RING_LAST);

`ifdef ALARM_SNOOZE_EN
    localparam logic [11:0] SNOOZE_LAST = 12'(SNOOZE_MIN * 60 - 1);

    logic [11:0] snooze_cnt;
    logic        snooze_done;

    assign snooze_done = sec_tick & (snooze_cnt == SNOOZE_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            snooze_cnt <= '0;
        else if (state != SNOOZED)
            snooze_cnt <= '0;
        else if (sec_tick)
            snooze_cnt <= snooze_cnt + 12'd1;
    end
`else
    logic [1:0] unused_snooze;
    assign unused_snooze = {snooze, 1'(SNOOZE_MIN)};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ring_cnt <= '0;
        else if (state != RINGING)
            ring_cnt <= '0;
        else if (sec_tick)
            ring_cnt <= ring_cnt + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (trigger) next_state = RINGING;
            end
            RINGING: begin
                if (alarm_off || !alarm_en)
                    next_state = IDLE;
`ifdef ALARM_SNOOZE_EN
                else if (snooze)
                    next_state = SNOOZED;
`endif
                else if (timeout)
                    next_state = IDLE;
            end
`ifdef ALARM_SNOOZE_EN
            SNOOZED: begin
                if (alarm_off || !alarm_en)
                    next_state = IDLE;
                else if (snooze_done)
                    next_state = RINGING;
            end
`endif
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        alarm_ring = (state == RINGING);
    end

endmodule

// File: tb/tb_alarm_timekeeper.sv
// Bench for alarm_timekeeper: directed scenarios plus random stimulus against a
// seconds-of-day / minutes-of-day reference model. Honours ALARM_SNOOZE_EN.
module tb_alarm_timekeeper;

    localparam int unsigned RS = 60;
    localparam int unsigned SM = 1;

    logic       clk;
    logic       rst;
    logic       tick_in;
    logic [1:0] mode;
    logic       inc_min;
    logic       inc_hr;
    logic       alarm_en;
    logic       alarm_off;
    logic       snooze;
    logic [7:0] hr_bcd;
    logic [7:0] min_bcd;
    logic [7:0] sec_bcd;
    logic [7:0] al_hr_bcd;
    logic [7:0] al_min_bcd;
    logic       sec_tick;
    logic       alarm_ring;

    int n_checks = 0;
    int n_fail   = 0;
    int st_count = 0;

    // reference model state
    int m_secs;
    int m_al;
    int m_state;
    int m_ring_left;
    int m_snz_left;
    bit m_tq;
    bit m_st;

    alarm_timekeeper #(.RING_SEC(RS), .SNOOZE_MIN(SM)) dut (
        .clk        (clk),
        .rst        (rst),
        .tick_in    (tick_in),
        .mode       (mode),
        .inc_min    (inc_min),
        .inc_hr     (inc_hr),
        .alarm_en   (alarm_en),
        .alarm_off  (alarm_off),
        .snooze     (snooze),
        .hr_bcd     (hr_bcd),
        .min_bcd    (min_bcd),
        .sec_bcd    (sec_bcd),
        .al_hr_bcd  (al_hr_bcd),
        .al_min_bcd (al_min_bcd),
        .sec_tick   (sec_tick),
        .alarm_ring (alarm_ring)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        logic [7:0] r;
        r[7:4] = 4'(v / 10);
        r[3:0] = 4'(v % 10);
        return r;
    endfunction

    task automatic model_step();
        bit rise, set_t, set_a, trig;
        int h, mi, ah, am;
        if (rst) begin
            m_secs = 0; m_al = 0; m_state = 0; m_tq = 0; m_st = 0;
            m_ring_left = 0; m_snz_left = 0;
            return;
        end
        rise  = tick_in && !m_tq;
        set_t = (mode == 2'd1);
        set_a = (mode == 2'd2);
        trig  = m_st && (m_secs % 60 == 0) && (m_secs / 60 == m_al) && alarm_en && !set_t && !set_a;
        case (m_state)
            0: if (trig) begin m_state = 1; m_ring_left = RS; end
            1: begin
                if (alarm_off || !alarm_en) m_state = 0;
`ifdef ALARM_SNOOZE_EN
                else if (snooze) begin m_state = 2; m_snz_left = SM * 60; end
`endif
                else if (m_st) begin
                    m_ring_left--;
                    if (m_ring_left == 0) m_state = 0;
                end
            end
            default: begin
                if (alarm_off || !alarm_en) m_state = 0;
                else if (m_st) begin
                    m_snz_left--;
                    if (m_snz_left == 0) begin m_state = 1; m_ring_left = RS; end
                end
            end
        endcase
        if (set_t) begin
            h  = m_secs / 3600;
            mi = (m_secs / 60) % 60;
            if (inc_min) mi = (mi + 1) % 60;
            if (inc_hr)  h  = (h + 1) % 24;
            m_secs = h * 3600 + mi * 60;
        end else if (rise) begin
            m_secs = (m_secs + 1) % 86400;
        end
        if (set_a) begin
            ah = m_al / 60;
            am = m_al % 60;
            if (inc_min) am = (am + 1) % 60;
            if (inc_hr)  ah = (ah + 1) % 24;
            m_al = ah * 60 + am;
        end
        m_st = rise && !set_t;
        m_tq = tick_in;
    endtask

    task automatic check_all();
        check("hr",    32'(hr_bcd),     32'(to_bcd(m_secs / 3600)));
        check("min",   32'(min_bcd),    32'(to_bcd((m_secs / 60) % 60)));
        check("sec",   32'(sec_bcd),    32'(to_bcd(m_secs % 60)));
        check("al_hr", 32'(al_hr_bcd),  32'(to_bcd(m_al / 60)));
        check("al_min",32'(al_min_bcd), 32'(to_bcd(m_al % 60)));
        check("sec_tick",   32'(sec_tick),   32'(m_st));
        check("alarm_ring", 32'(alarm_ring), 32'(m_state == 1));
    endtask

    task automatic cycle(input logic t, input logic [1:0] m, input logic im, input logic ih,
                         input logic en, input logic off, input logic sn);
        tick_in = t; mode = m; inc_min = im; inc_hr = ih;
        alarm_en = en; alarm_off = off; snooze = sn;
        model_step();
        @(posedge clk);
        #1;
        check_all();
        if (sec_tick) st_count++;
    endtask

    task automatic tick_secs(input int n, input logic [1:0] m, input logic en);
        for (int i = 0; i < n; i++) begin
            cycle(1'b1, m, 1'b0, 1'b0, en, 1'b0, 1'b0);
            cycle(1'b0, m, 1'b0, 1'b0, en, 1'b0, 1'b0);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        cycle(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_time(input string tag, input logic [7:0] h, input logic [7:0] mi,
                              input logic [7:0] s);
        check({tag, "_hr"},  32'(hr_bcd),  32'(h));
        check({tag, "_min"}, 32'(min_bcd), 32'(mi));
        check({tag, "_sec"}, 32'(sec_bcd), 32'(s));
    endtask

    initial begin
        logic [1:0] cur_mode;
        logic       cur_en;
        int         r;

        rst = 1'b1; tick_in = 1'b0; mode = 2'd0; inc_min = 1'b0; inc_hr = 1'b0;
        alarm_en = 1'b0; alarm_off = 1'b0; snooze = 1'b0;
        @(posedge clk);
        #1;

        // reset state and basic counting
        do_reset();
        check_time("rst", 8'h00, 8'h00, 8'h00);
        check("rst_ring", 32'(alarm_ring), 32'd0);
        st_count = 0;
        tick_secs(61, 2'd0, 1'b0);
        check_time("run61", 8'h00, 8'h01, 8'h01);
        check("sec_tick_count", 32'(st_count), 32'd61);

        // set time with tick edges present; minutes must not carry into hours
        do_reset();
        for (int i = 0; i < 75; i++)
            cycle(1'(i % 2), 2'd1, 1'b1, 1'(i < 3), 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_time("set", 8'h03, 8'h15, 8'h00);
        cycle(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_time("set_back", 8'h03, 8'h15, 8'h00);

        // alarm at 00:02, then stop with alarm_off
        do_reset();
        cycle(1'b0, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick_secs(120, 2'd0, 1'b1);
        check_time("al2", 8'h00, 8'h02, 8'h00);
        check("al2_ring", 32'(alarm_ring), 32'd1);
        cycle(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("al2_off", 32'(alarm_ring), 32'd0);
        tick_secs(30, 2'd0, 1'b1);
        check("al2_noretrig", 32'(alarm_ring), 32'd0);

        // midnight rollover with alarm 00:00, then auto timeout
        do_reset();
        for (int i = 0; i < 59; i++)
            cycle(1'b0, 2'd1, 1'b1, 1'(i < 23), 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick_secs(58, 2'd0, 1'b0);
        check_time("pre", 8'h23, 8'h59, 8'h58);
        tick_secs(2, 2'd0, 1'b1);
        check_time("midnight", 8'h00, 8'h00, 8'h00);
        check("midnight_ring", 32'(alarm_ring), 32'd1);
        tick_secs(RS - 1, 2'd0, 1'b1);
        check("ring_hold", 32'(alarm_ring), 32'd1);
        tick_secs(1, 2'd0, 1'b1);
        check("ring_timeout", 32'(alarm_ring), 32'd0);

        // snooze handling (ignored when the feature is not built)
        do_reset();
        cycle(1'b0, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick_secs(60, 2'd0, 1'b1);
        check("snz_ring", 32'(alarm_ring), 32'd1);
        cycle(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
`ifdef ALARM_SNOOZE_EN
        check("snz_drop", 32'(alarm_ring), 32'd0);
        tick_secs(SM * 60 - 1, 2'd0, 1'b1);
        check("snz_wait", 32'(alarm_ring), 32'd0);
        tick_secs(1, 2'd0, 1'b1);
        check("snz_rering", 32'(alarm_ring), 32'd1);
        cycle(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        tick_secs(10, 2'd0, 1'b1);
`else
        check("snz_ignored", 32'(alarm_ring), 32'd1);
        tick_secs(10, 2'd0, 1'b1);
`endif
        rst = 1'b1;
        #1;
        check_time("async_rst", 8'h00, 8'h00, 8'h00);
        check("async_rst_ring", 32'(alarm_ring), 32'd0);
        check("async_rst_tick", 32'(sec_tick), 32'd0);
        check("async_rst_al", 32'({al_hr_bcd, al_min_bcd}), 32'd0);
        cycle(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        cycle(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick_secs(5, 2'd0, 1'b1);
        check("post_rst_ring", 32'(alarm_ring), 32'd0);

        // random phase, alarm preset to 00:03
        do_reset();
        for (int i = 0; i < 3; i++)
            cycle(1'b0, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cur_mode = 2'd0;
        cur_en   = 1'b1;
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 99) < 2) begin
                r = int'($urandom_range(0, 9));
                cur_mode = (r < 6) ? 2'd0 : (r == 6) ? 2'd3 : (r == 7) ? 2'd1 : 2'd2;
            end
            if ($urandom_range(0, 299) == 0) cur_en = ~cur_en;
            cycle(1'($urandom_range(0, 1)), cur_mode,
                  1'($urandom_range(0, 99) < 4), 1'($urandom_range(0, 99) < 2), cur_en,
                  1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 99) < 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
